// File: rtl/org_bits.sv
// org_bits: datapath helper for the IR remote-control decoder.
// Holds two independent registered functions sharing one clock and reset:
//   - a saturating pulse-width up-counter used to time IR mark/space intervals;
//   - a bit-insertion register that assembles a command byte one bit at a time.
module org_bits #(
    parameter int CNT_W  = 17,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cnt_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              cnt_full,
    input  logic              bit_en,
    input  logic [IDX_W-1:0]  ordem,
    input  logic              b,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out
);

    // Saturation value: the counter parks here so a long pulse never reads as short.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_q, out_d;

    // Counter next state: clear beats enable, increment stops at all-ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Bit-insertion next state: copy the source word and overwrite one in-range bit.
    always_comb begin
        out_d = out_q;
        if (bit_en) begin
            out_d = in;
            // An index at or beyond DATA_W matches no iteration, so the word passes through unchanged.
            // Comparing the full index also keeps the upper ordem bits out of the data path.
            for (int unsigned i = 0; i < DATA_W; i++) begin
                if (32'(ordem) == i) begin
                    out_d[i] = b;
                end
            end
        end
    end

    // State registers for both functions, cleared asynchronously by the global reset.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
        if (!reset_n) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign cnt_out  = cnt_q;
    assign cnt_full = (cnt_q == CNT_MAX);
    assign out      = out_q;

endmodule

// File: tb/tb_org_bits.sv
// tb_org_bits: self-checking bench for org_bits.
// A behavioural model (plain integer arithmetic) tracks the expected outputs and is
// compared against the DUT on every falling clock edge; directed sequences from the
// test plan add literal expectations, then a randomized phase runs against the model.
// A second, narrow-counter instance makes counter saturation reachable in few cycles.
module tb_org_bits;

    localparam int CNT_W   = 17;
    localparam int CNT_W_S = 5;
    localparam int MAX_L   = (1 << CNT_W) - 1;
    localparam int MAX_S   = (1 << CNT_W_S) - 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cnt_en = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               bit_en = 1'b0;
    logic [7:0]         ordem = 8'd0;
    logic               b = 1'b0;
    logic [7:0]         d_in = 8'd0;
    logic [CNT_W-1:0]   cnt_out;
    logic               cnt_full;
    logic [7:0]         d_out;
    logic [CNT_W_S-1:0] cnt_out_s;
    logic               cnt_full_s;
    logic [7:0]         d_out_s;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int m_cnt   = 0;
    int m_cnt_s = 0;
    int m_out   = 0;

    org_bits #(.CNT_W(CNT_W), .DATA_W(8), .IDX_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .cnt_out(cnt_out), .cnt_full(cnt_full), .bit_en(bit_en), .ordem(ordem),
        .b(b), .in(d_in), .out(d_out)
    );

    org_bits #(.CNT_W(CNT_W_S), .DATA_W(8), .IDX_W(8)) dut_s (
        .clk(clk), .reset_n(reset_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .cnt_out(cnt_out_s), .cnt_full(cnt_full_s), .bit_en(bit_en), .ordem(ordem),
        .b(b), .in(d_in), .out(d_out_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: apply the specified rules to the inputs seen at each rising edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt   = 0;
            m_cnt_s = 0;
            m_out   = 0;
        end else begin
            if (cnt_clr) begin
                m_cnt   = 0;
                m_cnt_s = 0;
            end else if (cnt_en) begin
                m_cnt   = (m_cnt   < MAX_L) ? m_cnt + 1   : m_cnt;
                m_cnt_s = (m_cnt_s < MAX_S) ? m_cnt_s + 1 : m_cnt_s;
            end
            if (bit_en) begin
                if (int'(ordem) < 8)
                    m_out = (int'(d_in) & ~(1 << ordem)) | (int'(b) << ordem);
                else
                    m_out = int'(d_in);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cnt_out",    cnt_out,    m_cnt);
        check("cnt_full",   cnt_full,   (m_cnt == MAX_L) ? 1 : 0);
        check("out",        d_out,      m_out);
        check("cnt_out_s",  cnt_out_s,  m_cnt_s);
        check("cnt_full_s", cnt_full_s, (m_cnt_s == MAX_S) ? 1 : 0);
        check("out_s",      d_out_s,    m_out);
    end

    // One clock: rising edge, then settle past the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    logic [7:0] seq;

    initial begin
        // Reset held with activity on every input: outputs must stay zero.
        cnt_en = 1'b1; bit_en = 1'b1; d_in = 8'hFF; b = 1'b1; ordem = 8'd2;
        repeat (4) begin
            tick();
            check("rst_hold_cnt", cnt_out, 0);
            check("rst_hold_out", d_out, 0);
        end
        cnt_en = 1'b0; bit_en = 1'b0;
        reset_n = 1'b1;
        tick();

        // Count past the 0/1 threshold, hold, then clear with enable also high.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cnt_en = 1'b1;
        tick(23001);
        check("count_23001", cnt_out, 23001);
        cnt_en = 1'b0;
        tick(3);
        check("hold_23001", cnt_out, 23001);
        cnt_clr = 1'b1; cnt_en = 1'b1;
        tick();
        check("clr_over_en", cnt_out, 0);
        cnt_clr = 1'b0; cnt_en = 1'b0;

        // Saturation on the narrow instance: 30 edges to max-1, then 3 more.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cnt_en = 1'b1;
        tick(MAX_S - 1);
        check("sat_pre", cnt_out_s, MAX_S - 1);
        check("sat_pre_full", cnt_full_s, 0);
        tick(3);
        check("sat_val", cnt_out_s, MAX_S);
        check("sat_full", cnt_full_s, 1);
        cnt_en = 1'b0; cnt_clr = 1'b1;
        tick();
        check("sat_clr", cnt_out_s, 0);
        check("sat_clr_full", cnt_full_s, 0);
        cnt_clr = 1'b0;

        // Bit insertion basics.
        bit_en = 1'b1; d_in = 8'h00; ordem = 8'd3; b = 1'b1;
        tick();
        check("ins_bit3", d_out, 8'h08);
        d_in = 8'hFF; ordem = 8'd0; b = 1'b0;
        tick();
        check("ins_clr0", d_out, 8'hFE);
        bit_en = 1'b0; d_in = 8'h55;
        tick();
        check("ins_hold", d_out, 8'hFE);

        // Out-of-range indices pass the source word through.
        bit_en = 1'b1; d_in = 8'hA5; b = 1'b1; ordem = 8'd8;
        tick();
        check("oor_8", d_out, 8'hA5);
        d_in = 8'h00; tick();
        d_in = 8'hA5; ordem = 8'd255;
        tick();
        check("oor_255", d_out, 8'hA5);

        // LSB-first byte assembly with the output fed back as the source.
        d_in = 8'h00; ordem = 8'd8; tick();
        seq = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            d_in = d_out; ordem = 8'(i); b = seq[i];
            tick();
        end
        check("assemble", d_out, 8'h4D);
        // Same index written twice: last write wins.
        d_in = d_out; ordem = 8'd0; b = 1'b0; tick();
        d_in = d_out; ordem = 8'd0; b = 1'b1; tick();
        check("last_wins", d_out, 8'h4D);
        bit_en = 1'b0;

        // Asynchronous reset mid-count, checked before the next rising edge.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cnt_en = 1'b1;
        tick(500);
        check("pre_async", cnt_out, 500);
        #2 reset_n = 1'b0;
        #1;
        check("async_cnt", cnt_out, 0);
        check("async_out", d_out, 0);
        tick(2);
        check("async_hold", cnt_out, 0);
        cnt_en = 1'b0;
        reset_n = 1'b1;
        tick();

        // Randomized traffic on both functions against the model.
        for (int n = 0; n < 3000; n++) begin
            cnt_en  = ($urandom_range(0, 9) < 8);
            cnt_clr = ($urandom_range(0, 99) < 3);
            bit_en  = $urandom_range(0, 1);
            ordem   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            b       = $urandom_range(0, 1);
            d_in    = 8'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
